// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//  Instruction front end. Issues reads to a synchronous instruction memory
//  (1-cycle read latency), buffers returned words with their fetch addresses in
//  a small FIFO and presents the head to the decoder over valid/ready.
//  Supports start (IDLE only), stop (drain buffered words) and redirect
//  (flush + new PC, resumes fetching).
//
//  Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, start_addr        begin fetching at start_addr (IDLE only)
//   stop                     stop issuing reads, drain the buffer
//   redir_valid, redir_addr  flush everything and fetch from redir_addr
//   imem_en, imem_addr       memory read request
//   imem_rdata               memory read data, valid the cycle after imem_en
//   inst_valid, inst_data,
//   inst_pc, inst_ready      head-of-queue handshake to the decoder
//   busy                     high while fetching or draining
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic                  stop,
   input  logic                  redir_valid,
   input  logic [ADDR_WIDTH-1:0] redir_addr,
   output logic                  imem_en,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   output logic [INST_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  inst_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [DEPTH_LOG2+1:0] DEPTH_L = FIFO_DEPTH[DEPTH_LOG2+1:0];

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
   logic                    inflight_q, inflight_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [INST_WIDTH-1:0]   inst_data_q, inst_data_d;
   logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;
   logic                    busy_q, busy_d;

   logic [INST_WIDTH-1:0]   data_mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem_q   [FIFO_DEPTH];

   logic                    redir;
   logic                    issue;
   logic                    push;
   logic                    pop;
   logic                    head_is_new;
   logic [DEPTH_LOG2+1:0]   occupancy;

   always_comb begin
      redir     = redir_valid & (state_q != ST_IDLE);
      occupancy = {1'b0, count_q} + {{(DEPTH_LOG2 + 1){1'b0}}, inflight_q};
      // Reserve a slot for every outstanding read; a same-cycle pop is not credited.
      issue     = (state_q == ST_FETCH) & (occupancy < DEPTH_L) & ~redir_valid;
      push      = inflight_q & ~redir;
      pop       = (count_q != '0) & inst_ready & ~redir;
      // Head after this edge is the word being pushed when nothing older survives.
      head_is_new = (count_q == '0) | (pop & (count_q == {{DEPTH_LOG2{1'b0}}, 1'b1}));
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      inflight_d  = issue;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;

      if (issue) begin
         pc_d       = pc_q + 1'b1;
         req_addr_d = pc_q;
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = start_addr;
            end
         end
         ST_FETCH: begin
            if (stop) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((count_q == '0) && !inflight_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Redirect overrides everything decided above for this edge.
      if (redir) begin
         state_d    = ST_FETCH;
         pc_d       = redir_addr;
         inflight_d = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end

      // Output head is registered so it holds its last value while empty.
      if (count_d != '0) begin
         if (head_is_new) begin
            inst_data_d = imem_rdata;
            inst_pc_d   = req_addr_q;
         end else begin
            inst_data_d = data_mem_q[rd_ptr_d];
            inst_pc_d   = pc_mem_q[rd_ptr_d];
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         req_addr_q  <= '0;
         inflight_q  <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         inst_data_q <= inst_data_d;
         inst_pc_q   <= inst_pc_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         data_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]   <= req_addr_q;
      end
   end

   assign imem_en    = issue;
   assign imem_addr  = pc_q;
   assign inst_valid = (count_q != '0);
   assign inst_data  = inst_data_q;
   assign inst_pc    = inst_pc_q;
   assign busy       = busy_q;

endmodule
